// File: rtl/sgd_mem_rd_arbiter_pkg.sv
// rtl/sgd_mem_rd_arbiter_pkg.sv - shared tags, widths and route-state enum for the memory read arbiter
package sgd_mem_rd_arbiter_pkg;

    localparam int NUM_BITS_PER_CL         = 512;
    localparam int TAG_FIFO_DEPTH_BITS_DEF = 4;

    localparam logic [7:0] MEM_RD_A_TAG = 8'h0a;
    localparam logic [7:0] MEM_RD_B_TAG = 8'h0b;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROUTE_A = 2'd1,
        ST_ROUTE_B = 2'd2
    } route_state_e;

    // Tag FIFO entries are one bit: 0 = requester A, 1 = requester B.
    function automatic route_state_e route_for(input logic sel_b);
        return sel_b ? ST_ROUTE_B : ST_ROUTE_A;
    endfunction

    function automatic logic [7:0] tag_for(input logic sel_b);
        return sel_b ? MEM_RD_B_TAG : MEM_RD_A_TAG;
    endfunction

endpackage

// File: rtl/sgd_mem_rd_arbiter_tag_fifo.sv
// rtl/sgd_mem_rd_arbiter_tag_fifo.sv - in-order 1-bit requester tag FIFO with fall-through head
module sgd_tag_fifo #(
    parameter int DEPTH_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                push_sel,
    input  logic                pop,
    output logic                head,
    output logic                second,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_BITS:0] count
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_BITS:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_BITS:0]   CNT_FULL = {1'b1, {DEPTH_BITS{1'b0}}};

    logic [DEPTH-1:0]      mem_q, mem_d;
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic [DEPTH_BITS-1:0] rd_ptr_nx;
    logic                  do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign count     = count_q;
    assign rd_ptr_nx = rd_ptr_q + PTR_ONE;
    assign head      = mem_q[rd_ptr_q];
    assign second    = mem_q[rd_ptr_nx];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_sel;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_nx;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sgd_mem_rd_arbiter.sv
// rtl/sgd_mem_rd_arbiter.sv - round-robin read-command arbiter with in-order read-data steering
module sgd_mem_rd_arbiter
    import sgd_mem_rd_arbiter_pkg::*;
#(
    parameter int TAG_FIFO_DEPTH_BITS = TAG_FIFO_DEPTH_BITS_DEF,
    parameter int DATA_WIDTH          = NUM_BITS_PER_CL
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        a_cmd_valid,
    output logic                        a_cmd_ready,
    input  logic [63:0]                 a_cmd_address,
    input  logic [31:0]                 a_cmd_length,
    input  logic                        b_cmd_valid,
    output logic                        b_cmd_ready,
    input  logic [63:0]                 b_cmd_address,
    input  logic [31:0]                 b_cmd_length,
    output logic                        mem_cmd_valid,
    input  logic                        mem_cmd_ready,
    output logic [63:0]                 mem_cmd_address,
    output logic [31:0]                 mem_cmd_length,
    output logic [7:0]                  mem_cmd_tag,
    input  logic                        mem_rd_valid,
    output logic                        mem_rd_ready,
    input  logic [DATA_WIDTH-1:0]       mem_rd_data,
    input  logic [DATA_WIDTH/8-1:0]     mem_rd_keep,
    input  logic                        mem_rd_last,
    output logic                        a_rd_valid,
    input  logic                        a_rd_ready,
    output logic [DATA_WIDTH-1:0]       a_rd_data,
    output logic [DATA_WIDTH/8-1:0]     a_rd_keep,
    output logic                        a_rd_last,
    output logic                        b_rd_valid,
    input  logic                        b_rd_ready,
    output logic [DATA_WIDTH-1:0]       b_rd_data,
    output logic [DATA_WIDTH/8-1:0]     b_rd_keep,
    output logic                        b_rd_last,
    output logic [TAG_FIFO_DEPTH_BITS:0] outstanding,
    output logic                        err_zero_len
);

    localparam logic [TAG_FIFO_DEPTH_BITS:0] CNT_ONE = 1;

    logic        fifo_head, fifo_second, fifo_empty, fifo_full;
    logic [TAG_FIFO_DEPTH_BITS:0] fifo_count;

    logic        mem_cmd_valid_q, mem_cmd_valid_d;
    logic [63:0] mem_cmd_address_q, mem_cmd_address_d;
    logic [31:0] mem_cmd_length_q, mem_cmd_length_d;
    logic [7:0]  mem_cmd_tag_q, mem_cmd_tag_d;
    logic        last_grant_b_q, last_grant_b_d;
    logic        err_zero_len_q, err_zero_len_d;
    route_state_e state_q, state_d;

    logic        can_issue, grant_a, grant_b, grant, zero_len, push, pop;
    logic [63:0] g_addr;
    logic [31:0] g_len;

    // Uses the registered FIFO count only: a pop this cycle does not free a slot until next cycle.
    assign can_issue = (!mem_cmd_valid_q || mem_cmd_ready) && !fifo_full && !rst;
    assign grant_a   = can_issue && a_cmd_valid && (!b_cmd_valid || last_grant_b_q);
    assign grant_b   = can_issue && b_cmd_valid && (!a_cmd_valid || !last_grant_b_q);
    assign grant     = grant_a || grant_b;
    assign g_addr    = grant_b ? b_cmd_address : a_cmd_address;
    assign g_len     = grant_b ? b_cmd_length : a_cmd_length;
    assign zero_len  = grant && (g_len == 32'd0);
    assign push      = grant && !zero_len;

    assign a_cmd_ready     = grant_a;
    assign b_cmd_ready     = grant_b;
    assign mem_cmd_valid   = mem_cmd_valid_q;
    assign mem_cmd_address = mem_cmd_address_q;
    assign mem_cmd_length  = mem_cmd_length_q;
    assign mem_cmd_tag     = mem_cmd_tag_q;
    assign err_zero_len    = err_zero_len_q;
    assign outstanding     = fifo_count;

    assign a_rd_data = mem_rd_data;
    assign a_rd_keep = mem_rd_keep;
    assign a_rd_last = mem_rd_last;
    assign b_rd_data = mem_rd_data;
    assign b_rd_keep = mem_rd_keep;
    assign b_rd_last = mem_rd_last;

    always_comb begin
        mem_cmd_valid_d   = mem_cmd_valid_q;
        mem_cmd_address_d = mem_cmd_address_q;
        mem_cmd_length_d  = mem_cmd_length_q;
        mem_cmd_tag_d     = mem_cmd_tag_q;
        if (push) begin
            mem_cmd_valid_d   = 1'b1;
            mem_cmd_address_d = g_addr;
            mem_cmd_length_d  = g_len;
            mem_cmd_tag_d     = tag_for(grant_b);
        end else if (mem_cmd_ready) begin
            mem_cmd_valid_d = 1'b0;
        end
        last_grant_b_d = grant ? grant_b : last_grant_b_q;
        err_zero_len_d = zero_len;
    end

    always_comb begin
        state_d      = state_q;
        mem_rd_ready = 1'b0;
        a_rd_valid   = 1'b0;
        b_rd_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = route_for(fifo_head);
            end
            ST_ROUTE_A: begin
                a_rd_valid   = mem_rd_valid;
                mem_rd_ready = a_rd_ready;
            end
            ST_ROUTE_B: begin
                b_rd_valid   = mem_rd_valid;
                mem_rd_ready = b_rd_ready;
            end
            default: state_d = ST_IDLE;
        endcase
        pop = (state_q != ST_IDLE) && mem_rd_valid && mem_rd_ready && mem_rd_last;
        // On a last beat, jump straight to whoever owns the next head entry to avoid a bubble.
        if (pop) begin
            if (fifo_count > CNT_ONE)  state_d = route_for(fifo_second);
            else if (push)             state_d = route_for(grant_b);
            else                       state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cmd_valid_q   <= 1'b0;
            mem_cmd_address_q <= '0;
            mem_cmd_length_q  <= '0;
            mem_cmd_tag_q     <= '0;
            last_grant_b_q    <= 1'b1;
            err_zero_len_q    <= 1'b0;
            state_q           <= ST_IDLE;
        end else begin
            mem_cmd_valid_q   <= mem_cmd_valid_d;
            mem_cmd_address_q <= mem_cmd_address_d;
            mem_cmd_length_q  <= mem_cmd_length_d;
            mem_cmd_tag_q     <= mem_cmd_tag_d;
            last_grant_b_q    <= last_grant_b_d;
            err_zero_len_q    <= err_zero_len_d;
            state_q           <= state_d;
        end
    end

    sgd_tag_fifo #(
        .DEPTH_BITS (TAG_FIFO_DEPTH_BITS)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_sel (grant_b),
        .pop      (pop),
        .head     (fifo_head),
        .second   (fifo_second),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_sgd_mem_rd_arbiter.sv
// tb/tb_sgd_mem_rd_arbiter.sv - directed self-checking bench with a queue-based arbiter model
module tb_sgd_mem_rd_arbiter;
    import sgd_mem_rd_arbiter_pkg::*;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_cmd_valid = 0, a_cmd_ready, b_cmd_valid = 0, b_cmd_ready;
    logic [63:0]   a_cmd_address = 0, b_cmd_address = 0, mem_cmd_address;
    logic [31:0]   a_cmd_length = 0, b_cmd_length = 0, mem_cmd_length;
    logic          mem_cmd_valid, mem_cmd_ready = 1;
    logic [7:0]    mem_cmd_tag;
    logic          mem_rd_valid = 0, mem_rd_ready, mem_rd_last = 0;
    logic [DW-1:0] mem_rd_data = 0, a_rd_data, b_rd_data;
    logic [KW-1:0] mem_rd_keep = 0, a_rd_keep, b_rd_keep;
    logic          a_rd_valid, a_rd_ready = 1, a_rd_last;
    logic          b_rd_valid, b_rd_ready = 1, b_rd_last;
    logic [4:0]    outstanding;
    logic          err_zero_len;

    sgd_mem_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .a_cmd_valid(a_cmd_valid), .a_cmd_ready(a_cmd_ready),
        .a_cmd_address(a_cmd_address), .a_cmd_length(a_cmd_length),
        .b_cmd_valid(b_cmd_valid), .b_cmd_ready(b_cmd_ready),
        .b_cmd_address(b_cmd_address), .b_cmd_length(b_cmd_length),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_address(mem_cmd_address), .mem_cmd_length(mem_cmd_length),
        .mem_cmd_tag(mem_cmd_tag),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
        .mem_rd_data(mem_rd_data), .mem_rd_keep(mem_rd_keep), .mem_rd_last(mem_rd_last),
        .a_rd_valid(a_rd_valid), .a_rd_ready(a_rd_ready), .a_rd_data(a_rd_data),
        .a_rd_keep(a_rd_keep), .a_rd_last(a_rd_last),
        .b_rd_valid(b_rd_valid), .b_rd_ready(b_rd_ready), .b_rd_data(b_rd_data),
        .b_rd_keep(b_rd_keep), .b_rd_last(b_rd_last),
        .outstanding(outstanding), .err_zero_len(err_zero_len)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model state: pending command register, grant history, tag order, route activity.
    bit          mc_v = 0;
    logic [63:0] mc_addr = 0;
    logic [31:0] mc_len = 0;
    logic [7:0]  mc_tag = 0;
    bit          last_b = 1;
    bit          tq[$];
    bit          active = 0;
    bit          err = 0;

    bit          n_mc_v, n_last_b, n_active, n_err, have_next = 0;
    logic [63:0] n_mc_addr;
    logic [31:0] n_mc_len;
    logic [7:0]  n_mc_tag;
    bit          n_tq[$];

    logic [7:0]  tag_log[$];
    bit          dest_log[$];
    int          grant_cnt = 0;
    int          err_cnt = 0;

    always @(negedge clk) begin
        bit can, ga, gb, tgt, e_ard, e_brd, e_mrr, pop, push;
        logic [31:0] g_len;
        int old_size;
        if (rst) begin
            mc_v = 0; mc_addr = 0; mc_len = 0; mc_tag = 0;
            last_b = 1; tq.delete(); active = 0; err = 0; have_next = 0;
            chk("rst_mem_cmd_valid", mem_cmd_valid, 0);
            chk("rst_a_cmd_ready", a_cmd_ready, 0);
            chk("rst_b_cmd_ready", b_cmd_ready, 0);
            chk("rst_outstanding", outstanding, 0);
            chk("rst_err_zero_len", err_zero_len, 0);
            chk("rst_mem_rd_ready", mem_rd_ready, 0);
            chk("rst_a_rd_valid", a_rd_valid, 0);
            chk("rst_b_rd_valid", b_rd_valid, 0);
        end else begin
            can = (!mc_v || mem_cmd_ready) && (tq.size() < 16);
            ga  = can && a_cmd_valid && (!b_cmd_valid || last_b);
            gb  = can && b_cmd_valid && (!a_cmd_valid || !last_b);
            chk("a_cmd_ready", a_cmd_ready, ga);
            chk("b_cmd_ready", b_cmd_ready, gb);
            chk("mem_cmd_valid", mem_cmd_valid, mc_v);
            if (mc_v) begin
                chk("mem_cmd_address", mem_cmd_address, mc_addr);
                chk("mem_cmd_length", mem_cmd_length, mc_len);
                chk("mem_cmd_tag", mem_cmd_tag, mc_tag);
            end
            chk("outstanding", outstanding, tq.size());
            chk("err_zero_len", err_zero_len, err);
            tgt = active ? tq[0] : 1'b0;
            e_ard = active && !tgt && mem_rd_valid;
            e_brd = active && tgt && mem_rd_valid;
            e_mrr = active && (tgt ? b_rd_ready : a_rd_ready);
            chk("a_rd_valid", a_rd_valid, e_ard);
            chk("b_rd_valid", b_rd_valid, e_brd);
            chk("mem_rd_ready", mem_rd_ready, e_mrr);
            if (e_ard) begin
                chk("a_rd_data", a_rd_data, mem_rd_data);
                chk("a_rd_keep", a_rd_keep, mem_rd_keep);
                chk("a_rd_last", a_rd_last, mem_rd_last);
            end
            if (e_brd) begin
                chk("b_rd_data", b_rd_data, mem_rd_data);
                chk("b_rd_keep", b_rd_keep, mem_rd_keep);
                chk("b_rd_last", b_rd_last, mem_rd_last);
            end

            if (mem_cmd_valid && mem_cmd_ready) tag_log.push_back(mem_cmd_tag);
            if ((a_cmd_valid && a_cmd_ready) || (b_cmd_valid && b_cmd_ready)) grant_cnt++;
            if (err_zero_len) err_cnt++;
            if (a_rd_valid && a_rd_ready) dest_log.push_back(1'b0);
            if (b_rd_valid && b_rd_ready) dest_log.push_back(1'b1);

            pop   = active && mem_rd_valid && e_mrr && mem_rd_last;
            g_len = gb ? b_cmd_length : a_cmd_length;
            push  = (ga || gb) && (g_len != 0);
            old_size = tq.size();
            n_tq = tq;
            if (pop) void'(n_tq.pop_front());
            if (push) n_tq.push_back(gb);
            n_active  = active ? (pop ? (n_tq.size() > 0) : 1'b1) : (old_size > 0);
            n_mc_v = mc_v; n_mc_addr = mc_addr; n_mc_len = mc_len; n_mc_tag = mc_tag;
            if (push) begin
                n_mc_v = 1;
                n_mc_addr = gb ? b_cmd_address : a_cmd_address;
                n_mc_len = g_len;
                n_mc_tag = gb ? 8'h0b : 8'h0a;
            end else if (mem_cmd_ready) begin
                n_mc_v = 0;
            end
            n_err    = (ga || gb) && (g_len == 0);
            n_last_b = (ga || gb) ? gb : last_b;
            have_next = 1;
        end
    end

    always @(posedge clk) begin
        if (!rst && have_next) begin
            mc_v = n_mc_v; mc_addr = n_mc_addr; mc_len = n_mc_len; mc_tag = n_mc_tag;
            tq = n_tq; active = n_active; err = n_err; last_b = n_last_b;
            have_next = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tag_log.delete();
        dest_log.delete();
        grant_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic req(input bit sel_b, input logic [63:0] addr, input logic [31:0] len);
        bit got = 0;
        if (sel_b) begin b_cmd_valid = 1; b_cmd_address = addr; b_cmd_length = len; end
        else       begin a_cmd_valid = 1; a_cmd_address = addr; a_cmd_length = len; end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = sel_b ? b_cmd_ready : a_cmd_ready;
            tick();
        end
        if (!got) chk("req_timeout", 0, 1);
        if (sel_b) b_cmd_valid = 0;
        else       a_cmd_valid = 0;
    endtask

    task automatic beat(input bit last, input logic [31:0] seed);
        bit got = 0;
        mem_rd_valid = 1;
        mem_rd_last  = last;
        mem_rd_data  = {16{seed}};
        mem_rd_keep  = {2{seed}};
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = mem_rd_ready;
            tick();
        end
        if (!got) chk("beat_timeout", 0, 1);
        mem_rd_valid = 0;
        mem_rd_last  = 0;
    endtask

    function automatic logic [31:0] pack_tags();
        logic [31:0] p = 0;
        foreach (tag_log[i]) if (i < 4) p[31 - 8*i -: 8] = tag_log[i];
        return p;
    endfunction

    function automatic int count_dest(input bit d);
        int n = 0;
        foreach (dest_log[i]) if (dest_log[i] == d) n++;
        return n;
    endfunction

    function automatic logic [3:0] pack_dest();
        logic [3:0] p = 0;
        foreach (dest_log[i]) if (i < 4) p[3 - i] = dest_log[i];
        return p;
    endfunction

    initial begin
        do_reset();

        // A only, 0x1000 / 256 bytes, four beats back.
        req(0, 64'h1000, 32'd256);
        chk("t1_cmd_valid_after_1", mem_cmd_valid, 1);
        chk("t1_cmd_tag", mem_cmd_tag, 8'h0a);
        chk("t1_cmd_addr", mem_cmd_address, 64'h1000);
        chk("t1_outstanding_1", outstanding, 1);
        for (int i = 0; i < 4; i++) beat(i == 3, 32'hA000_0000 + i);
        tick();
        chk("t1_outstanding_0", outstanding, 0);
        chk("t1_a_beats", count_dest(0), 4);
        chk("t1_b_beats", count_dest(1), 0);

        // Both requesters continuously valid: strict alternation from A.
        do_reset();
        a_cmd_address = 64'h2000; a_cmd_length = 64;
        b_cmd_address = 64'h3000; b_cmd_length = 64;
        a_cmd_valid = 1; b_cmd_valid = 1;
        for (int i = 0; i < 20 && grant_cnt < 4; i++) tick();
        a_cmd_valid = 0; b_cmd_valid = 0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) beat(1, 32'hB000_0000 + i);
        tick();
        chk("t2_tag_count", tag_log.size(), 4);
        chk("t2_tag_order", pack_tags(), 32'h0a0b0a0b);
        chk("t2_dest_count", dest_log.size(), 4);
        chk("t2_dest_order", pack_dest(), 4'b0101);

        // Memory stalls the command port for 10 cycles.
        do_reset();
        mem_cmd_ready = 0;
        a_cmd_address = 64'h4000; a_cmd_length = 64;
        b_cmd_address = 64'h4100; b_cmd_length = 64;
        a_cmd_valid = 1; b_cmd_valid = 1;
        repeat (10) tick();
        chk("t3_single_grant", grant_cnt, 1);
        chk("t3_held_addr", mem_cmd_address, 64'h4000);
        a_cmd_valid = 0; b_cmd_valid = 0;
        tick();
        mem_cmd_ready = 1;
        tick();
        chk("t3_issued_one", tag_log.size(), 1);
        beat(1, 32'hC000_0001);
        tick();
        chk("t3_drained", outstanding, 0);

        // Fill all 16 tag slots, then free one with a last beat.
        do_reset();
        a_cmd_address = 64'h5000; a_cmd_length = 64;
        a_cmd_valid = 1;
        for (int i = 0; i < 40 && grant_cnt < 16; i++) tick();
        repeat (5) tick();
        chk("t4_grants_16", grant_cnt, 16);
        chk("t4_outstanding_16", outstanding, 16);
        chk("t4_17th_blocked", a_cmd_ready, 0);
        mem_rd_valid = 1; mem_rd_last = 1; mem_rd_data = {16{32'hD00D_0001}};
        tick();
        mem_rd_valid = 0; mem_rd_last = 0;
        tick();
        a_cmd_valid = 0;
        chk("t4_17th_granted", grant_cnt, 17);
        chk("t4_outstanding_refill", outstanding, 16);

        // Zero-length command from B.
        do_reset();
        req(1, 64'h6000, 32'd0);
        repeat (3) tick();
        chk("t5_err_pulses", err_cnt, 1);
        chk("t5_no_issue", tag_log.size(), 0);
        chk("t5_outstanding", outstanding, 0);

        // Reset while routing to B with three commands outstanding.
        do_reset();
        b_rd_ready = 0;
        for (int i = 0; i < 3; i++) req(1, 64'h7000 + 64'(i) * 64'h40, 32'd64);
        repeat (3) tick();
        mem_rd_valid = 1; mem_rd_data = {16{32'hE000_0001}};
        tick();
        chk("t6_routing_b", b_rd_valid, 1);
        chk("t6_outstanding_3", outstanding, 3);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("t6_async_outstanding", outstanding, 0);
        chk("t6_async_mem_rd_ready", mem_rd_ready, 0);
        chk("t6_async_b_rd_valid", b_rd_valid, 0);
        chk("t6_async_mem_cmd_valid", mem_cmd_valid, 0);
        mem_rd_valid = 0;
        b_rd_ready = 1;
        tick();
        tick();
        rst = 0;
        tag_log.delete();
        req(0, 64'h8000, 32'd64);
        tick();
        chk("t6_post_issue_count", tag_log.size(), 1);
        chk("t6_post_issue_tag", pack_tags(), 32'h0a000000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sgd_mem_rd_arbiter.md
Name: sgd_mem_rd_arbiter

Overview:
- Shares the single memory read path (one axis_mem_cmd master, one 512-bit read-data stream) between two requesters.
  - Requester A: training-dataset fetcher.
  - Requester B: label/b-vector fetcher.
- Round-robin arbitration of read commands; every issued command is tagged MEM_RD_A_TAG (8'h0a) or MEM_RD_B_TAG (8'h0b).
- Returning data is steered back to the issuing requester in command order, using an in-order tag FIFO.
- Sits between the SGD engine fetch logic and the DMA/memory controller.

Parameters:
- TAG_FIFO_DEPTH_BITS, 4, log2 of the maximum number of outstanding read commands (16).
- DATA_WIDTH, `NUM_BITS_PER_CL (512), read-data width in bits; keep width is DATA_WIDTH/8.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset, asynchronous, active-high.
- a_cmd_valid / a_cmd_ready  in / out  1 / 1  requester A command handshake.
- a_cmd_address / a_cmd_length  in  64 / 32  A byte address / byte length.
- b_cmd_valid, b_cmd_ready, b_cmd_address, b_cmd_length  same as A, for requester B.
- mem_cmd_valid / mem_cmd_ready  out / in  1 / 1  memory command handshake.
- mem_cmd_address / mem_cmd_length / mem_cmd_tag  out  64 / 32 / 8  issued command.
- mem_rd_valid / mem_rd_ready  in / out  1 / 1  returning data handshake.
- mem_rd_data / mem_rd_keep / mem_rd_last  in  512 / 64 / 1  returning beat.
- a_rd_valid / a_rd_ready  out / in  1 / 1  steered data to A.
- a_rd_data / a_rd_keep / a_rd_last  out  512 / 64 / 1  beat to A.
- b_rd_valid, b_rd_ready, b_rd_data, b_rd_keep, b_rd_last  same as A, for B.
- outstanding  out  TAG_FIFO_DEPTH_BITS+1  commands issued whose last data beat has not returned.
- err_zero_len  out  1  one-cycle pulse when a zero-length command is dropped.

Behaviour:
- Reset (async assert, sync deassert usage):
  - mem_cmd_valid=0, address/length/tag=0.
  - Tag FIFO empty, outstanding=0, last_grant=B (so A wins first tie), err_zero_len=0, route FSM=IDLE.
- Command side, output-registered:
  - can_issue = (!mem_cmd_valid || mem_cmd_ready) && (fifo_count < 2^TAG_FIFO_DEPTH_BITS).
  - Grant when can_issue and at least one request is valid.
    - Both valid: grant the requester not in last_grant.
    - Only one valid: grant that one.
  - Granted requester's cmd_ready=1 in the same cycle; the other's ready=0. Ready is never asserted without a grant.
  - On grant, next cycle:
    - mem_cmd_valid=1, fields captured from the granted requester;
    - tag pushed to the FIFO;
    - last_grant updated.
  - Command latency: 1 cycle from accepted request to mem_cmd_valid.
  - mem_cmd_valid with its fields stays stable until mem_cmd_ready.
  - A back-to-back grant is allowed in the same cycle mem_cmd_ready completes the previous command.
- Zero-length command:
  - Accepted (ready=1) when granted; not forwarded, not tagged.
  - err_zero_len pulses 1 on the next cycle.
  - last_grant still advances.
- FIFO full:
  - Uses the registered count; no bypass. A pop in the same cycle does not allow a push.
  - All cmd_ready stay 0 until the count drops.
- Route FSM: IDLE, ROUTE_A, ROUTE_B.
  - IDLE, FIFO non-empty: move to ROUTE_A or ROUTE_B by the head tag (1-cycle bubble).
  - IDLE, FIFO empty: mem_rd_ready=0. Data arriving with no outstanding command stalls; it is never dropped.
  - ROUTE_x: data/keep/last pass combinationally to x.
    - x_rd_valid = mem_rd_valid; mem_rd_ready = x_rd_ready. The other requester's valid is 0.
  - Beat accepted with last=1: pop the head. Next state: ROUTE of the new head if non-empty (no bubble), else IDLE.
- outstanding = FIFO count.
  - +1 on push, −1 on pop; simultaneous push and pop leaves it unchanged.
- Reset mid-operation:
  - Clears the FIFO and FSM immediately.
  - In-flight memory responses after reset are the system's responsibility; the block does not filter them.

Decomposition:
- Shared package / defines file:
  - MEM_RD_A_TAG, MEM_RD_B_TAG, NUM_BITS_PER_CL;
  - route-state enum (IDLE, ROUTE_A, ROUTE_B);
  - TAG_FIFO_DEPTH_BITS default.
- One sub-module: sgd_tag_fifo.
  - Synchronous FIFO, 1-bit entries (0=A, 1=B), first-word-fall-through head, count output.
  - Async active-high reset.

Test Plan:
- A only, address 0x1000, length 256 → mem_cmd issued 1 cycle later with tag 8'h0a. 4 beats return, last on the 4th → all four appear on a_rd, none on b_rd. outstanding goes 0→1→0.
- A and B both valid continuously, lengths 64 → issue order A,B,A,B with tags 0a,0b,0a,0b. Interleaved single-beat returns reach A,B,A,B respectively.
- mem_cmd_ready held 0 for 10 cycles with both requesters valid → mem_cmd_valid held, fields stable, both cmd_ready=0 after the first grant.
- 16 A commands issued, no data returned → outstanding=16. 17th request gets no ready. After one last beat, the 17th is granted on the following cycle.
- B command with length 0 → b_cmd_ready=1 for one cycle, no mem_cmd_valid, err_zero_len=1 on the next cycle, outstanding unchanged.
- rst asserted while ROUTE_B with 3 outstanding → outputs zero asynchronously, outstanding=0, mem_rd_ready=0. After release, a new A request issues normally.
